// File: rtl/unified_buffer_ctrl.sv
// unified_buffer_ctrl
//   Byte-wide unified buffer with an operand sequencer that feeds a 2x2
//   systolic array. The control unit's command levels are turned into single
//   operations on their rising edges:
//     WEIGHT : two beats of two weights read from buf[b..b+3]
//     INPUT  : input beats from buf[b..b+3], one word per array row
//     STORE  : the two accumulator results are written back as four bytes
//   A host side port writes the buffer and reads it back one cycle later.
//
// Build option:
//   UB_INPUT_SKEW_EN  defined   : INPUT is 3 skewed beats (b,0) (b+1,b+2) (0,b+3)
//                     undefined : INPUT is 2 beats (b,b+2) (b+1,b+3)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   base_address                     operation base, low log2(DEPTH) bits used
//   load_weight/load_input/store     command levels from the control unit
//   host_we/host_addr/host_wdata     host buffer write
//   host_rdata                       registered read of host_addr
//   acc_0, acc_1                     array column results captured by STORE
//   weight_valid, weight_0/1         weight beat
//   input_valid, input_0/1           input beat, array rows 0/1
//   busy                             sequencer active
//   overrun                          sticky: a command edge was dropped
module unified_buffer_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int DEPTH  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [12:0]              base_address,
   input  logic                     load_weight,
   input  logic                     load_input,
   input  logic                     store,
   input  logic                     host_we,
   input  logic [$clog2(DEPTH)-1:0] host_addr,
   input  logic [DATA_W-1:0]        host_wdata,
   output logic [DATA_W-1:0]        host_rdata,
   input  logic [ACC_W-1:0]         acc_0,
   input  logic [ACC_W-1:0]         acc_1,
   output logic                     weight_valid,
   output logic [DATA_W-1:0]        weight_0,
   output logic [DATA_W-1:0]        weight_1,
   output logic                     input_valid,
   output logic [DATA_W-1:0]        input_0,
   output logic [DATA_W-1:0]        input_1,
   output logic                     busy,
   output logic                     overrun
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WEIGHT, ST_INPUT, ST_STORE} state_t;

   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [1:0] k);
      return a + AW'(k);
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_t            state_q;
   logic [1:0]        cnt_q;
   logic [AW-1:0]     b_q;
   logic [ACC_W-1:0]  acc0_q, acc1_q;
   logic              lw_q, li_q, st_q;
   logic              wv_q, iv_q, busy_q, ovr_q;
   logic [DATA_W-1:0] w0_q, w1_q, i0_q, i1_q, rdata_q;

   logic [AW-1:0]     base_d;
   logic              lw_rise_d, li_rise_d, st_rise_d;
   logic              st_we_d;
   logic [AW-1:0]     st_addr_d;
   logic [DATA_W-1:0] st_byte_d;
   logic              unused_base;

   assign base_d      = base_address[AW-1:0];
   assign unused_base = ^base_address[12:AW];
   assign lw_rise_d   = load_weight & ~lw_q;
   assign li_rise_d   = load_input & ~li_q;
   assign st_rise_d   = store & ~st_q;

   // A reset edge must not complete the pending STORE byte.
   assign st_we_d   = (state_q == ST_STORE) & ~reset;
   assign st_addr_d = wrap_add(b_q, cnt_q);

   always_comb begin
      st_byte_d = '0;
      case (cnt_q)
         2'd0:    st_byte_d = acc0_q[DATA_W-1:0];
         2'd1:    st_byte_d = acc0_q[ACC_W-1:DATA_W];
         2'd2:    st_byte_d = acc1_q[DATA_W-1:0];
         default: st_byte_d = acc1_q[ACC_W-1:DATA_W];
      endcase
   end

   // Buffer storage: a STORE byte discards any host write in the same cycle.
   always_ff @(posedge clk) begin
      if (st_we_d) begin
         mem_q[st_addr_d] <= st_byte_d;
      end else if (host_we) begin
         mem_q[host_addr] <= host_wdata;
      end
   end

   // Non-blocking read returns the pre-write value on a same-address write.
   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= mem_q[host_addr];
   end

   // Sequencer. WEIGHT/INPUT emit beat 0 on the accepting edge, so cnt_q
   // holds the index of the next beat; STORE uses cnt_q as the byte index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         b_q     <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
         lw_q    <= 1'b0;
         li_q    <= 1'b0;
         st_q    <= 1'b0;
         wv_q    <= 1'b0;
         w0_q    <= '0;
         w1_q    <= '0;
         iv_q    <= 1'b0;
         i0_q    <= '0;
         i1_q    <= '0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         lw_q <= load_weight;
         li_q <= load_input;
         st_q <= store;
         wv_q <= 1'b0;
         w0_q <= '0;
         w1_q <= '0;
         iv_q <= 1'b0;
         i0_q <= '0;
         i1_q <= '0;

         case (state_q)
            ST_IDLE: begin
               if (st_rise_d) begin
                  state_q <= ST_STORE;
                  b_q     <= base_d;
                  acc0_q  <= acc_0;
                  acc1_q  <= acc_1;
                  cnt_q   <= 2'd0;
                  busy_q  <= 1'b1;
                  if (lw_rise_d | li_rise_d) ovr_q <= 1'b1;
               end else if (lw_rise_d) begin
                  state_q <= ST_WEIGHT;
                  b_q     <= base_d;
                  cnt_q   <= 2'd1;
                  busy_q  <= 1'b1;
                  wv_q    <= 1'b1;
                  w0_q    <= mem_q[base_d];
                  w1_q    <= mem_q[wrap_add(base_d, 2'd1)];
                  if (li_rise_d) ovr_q <= 1'b1;
               end else if (li_rise_d) begin
                  state_q <= ST_INPUT;
                  b_q     <= base_d;
                  cnt_q   <= 2'd1;
                  busy_q  <= 1'b1;
                  iv_q    <= 1'b1;
                  i0_q    <= mem_q[base_d];
`ifdef UB_INPUT_SKEW_EN
                  i1_q    <= '0;
`else
                  i1_q    <= mem_q[wrap_add(base_d, 2'd2)];
`endif
               end
            end
            ST_WEIGHT: begin
               if (cnt_q == 2'd1) begin
                  wv_q  <= 1'b1;
                  w0_q  <= mem_q[wrap_add(b_q, 2'd2)];
                  w1_q  <= mem_q[wrap_add(b_q, 2'd3)];
                  cnt_q <= 2'd2;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_INPUT: begin
`ifdef UB_INPUT_SKEW_EN
               case (cnt_q)
                  2'd1: begin
                     iv_q  <= 1'b1;
                     i0_q  <= mem_q[wrap_add(b_q, 2'd1)];
                     i1_q  <= mem_q[wrap_add(b_q, 2'd2)];
                     cnt_q <= 2'd2;
                  end
                  2'd2: begin
                     iv_q  <= 1'b1;
                     i1_q  <= mem_q[wrap_add(b_q, 2'd3)];
                     cnt_q <= 2'd3;
                  end
                  default: begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               endcase
`else
               if (cnt_q == 2'd1) begin
                  iv_q  <= 1'b1;
                  i0_q  <= mem_q[wrap_add(b_q, 2'd1)];
                  i1_q  <= mem_q[wrap_add(b_q, 2'd3)];
                  cnt_q <= 2'd2;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
`endif
            end
            default: begin
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase

         if ((state_q != ST_IDLE) && (lw_rise_d | li_rise_d | st_rise_d)) ovr_q <= 1'b1;
      end
   end

   assign host_rdata   = rdata_q;
   assign weight_valid = wv_q;
   assign weight_0     = w0_q;
   assign weight_1     = w1_q;
   assign input_valid  = iv_q;
   assign input_0      = i0_q;
   assign input_1      = i1_q;
   assign busy         = busy_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_unified_buffer_ctrl.sv
module tb_unified_buffer_ctrl;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int DEPTH  = 32;
   localparam int AW     = 5;
`ifdef UB_INPUT_SKEW_EN
   localparam int IN_BEATS = 3;
`else
   localparam int IN_BEATS = 2;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [12:0]       base_address;
   logic              load_weight, load_input, store;
   logic              host_we;
   logic [AW-1:0]     host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic [DATA_W-1:0] host_rdata;
   logic [ACC_W-1:0]  acc_0, acc_1;
   logic              weight_valid, input_valid, busy, overrun;
   logic [DATA_W-1:0] weight_0, weight_1, input_0, input_1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference buffer contents as the host and STORE operations define them.
   logic [7:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   unified_buffer_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .base_address(base_address),
      .load_weight(load_weight), .load_input(load_input), .store(store),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .acc_0(acc_0), .acc_1(acc_1),
      .weight_valid(weight_valid), .weight_0(weight_0), .weight_1(weight_1),
      .input_valid(input_valid), .input_0(input_0), .input_1(input_1),
      .busy(busy), .overrun(overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] wa(input logic [AW-1:0] b, input int k);
      return AW'((int'(b) + k) % DEPTH);
   endfunction

   // Expected row value of input beat k.
   function automatic logic [7:0] exp_in(input logic [AW-1:0] b, input int k, input int row);
      int idx;
`ifdef UB_INPUT_SKEW_EN
      if (row == 0) idx = (k < 2) ? k : -1;
      else          idx = (k > 0) ? k + 1 : -1;
`else
      idx = (row == 0) ? k : k + 2;
`endif
      return (idx < 0) ? 8'h00 : mem_m[wa(b, idx)];
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_wv"},   32'(weight_valid), 32'd0);
      chk({tag, "_w0"},   32'(weight_0), 32'd0);
      chk({tag, "_w1"},   32'(weight_1), 32'd0);
      chk({tag, "_iv"},   32'(input_valid), 32'd0);
      chk({tag, "_i0"},   32'(input_0), 32'd0);
      chk({tag, "_i1"},   32'(input_1), 32'd0);
   endtask

   task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
      host_addr  = a;
      host_wdata = d;
      host_we    = 1'b1;
      tick();
      host_we    = 1'b0;
      mem_m[a]   = d;
   endtask

   task automatic host_chk(input logic [AW-1:0] a, input string tag);
      host_addr = a;
      tick();
      chk(tag, 32'(host_rdata), 32'(mem_m[a]));
   endtask

   task automatic host_chk_c(input logic [AW-1:0] a, input logic [7:0] exp, input string tag);
      host_addr = a;
      tick();
      chk(tag, 32'(host_rdata), 32'(exp));
   endtask

   task automatic do_weight(input logic [AW-1:0] b, input int hold, input bit inj);
      base_address = {8'($urandom), b};
      load_weight  = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("w_busy", 32'(busy), 32'd1);
         chk("w_vld",  32'(weight_valid), 32'd1);
         chk("w_d0",   32'(weight_0), 32'(mem_m[wa(b, 2*k)]));
         chk("w_d1",   32'(weight_1), 32'(mem_m[wa(b, 2*k + 1)]));
         chk("w_iv",   32'(input_valid), 32'd0);
         if (k + 1 >= hold) load_weight = 1'b0;
         if (inj) load_input = (k == 0);
         tick();
      end
      load_weight = 1'b0;
      chk_idle("w_end");
   endtask

   task automatic do_input(input logic [AW-1:0] b, input int hold);
      base_address = {8'($urandom), b};
      load_input   = 1'b1;
      tick();
      for (int k = 0; k < IN_BEATS; k++) begin
         chk("i_busy", 32'(busy), 32'd1);
         chk("i_vld",  32'(input_valid), 32'd1);
         chk("i_d0",   32'(input_0), 32'(exp_in(b, k, 0)));
         chk("i_d1",   32'(input_1), 32'(exp_in(b, k, 1)));
         chk("i_wv",   32'(weight_valid), 32'd0);
         if (k + 1 >= hold) load_input = 1'b0;
         tick();
      end
      load_input = 1'b0;
      chk_idle("i_end");
   endtask

   // coll_byte: byte index whose write cycle also carries a host write (-1 none)
   // rst_at   : byte index whose write cycle asserts reset instead (-1 none)
   task automatic do_store(input logic [AW-1:0] b, input logic [15:0] a0, input logic [15:0] a1,
                           input int coll_byte, input logic [AW-1:0] coll_addr,
                           input logic [7:0] coll_data, input int rst_at, input bit others);
      logic [31:0] word;
      bit aborted;
      word    = {a1, a0};
      aborted = 1'b0;
      base_address = {8'($urandom), b};
      acc_0 = a0;
      acc_1 = a1;
      store = 1'b1;
      if (others) begin
         load_weight = 1'b1;
         load_input  = 1'b1;
      end
      tick();
      store       = 1'b0;
      load_weight = 1'b0;
      load_input  = 1'b0;
      acc_0 = 16'($urandom);
      acc_1 = 16'($urandom);
      for (int j = 0; j < 4 && !aborted; j++) begin
         if (j == rst_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk_idle("s_rst");
            chk("s_rst_ovr", 32'(overrun), 32'd0);
            chk("s_rst_rd",  32'(host_rdata), 32'd0);
            aborted = 1'b1;
         end else begin
            chk("s_busy", 32'(busy), 32'd1);
            chk("s_wv",   32'(weight_valid), 32'd0);
            chk("s_iv",   32'(input_valid), 32'd0);
            if (j == coll_byte) begin
               host_addr  = coll_addr;
               host_wdata = coll_data;
               host_we    = 1'b1;
            end
            tick();
            host_we = 1'b0;
            mem_m[wa(b, j)] = word[8*j +: 8];
         end
      end
      if (!aborted) chk_idle("s_end");
   endtask

   initial begin
      logic [7:0]    old_v;
      logic [AW-1:0] rb;
      int            op;

      reset = 1'b1;
      base_address = '0;
      load_weight = 1'b0;
      load_input  = 1'b0;
      store       = 1'b0;
      host_we     = 1'b0;
      host_addr   = '0;
      host_wdata  = '0;
      acc_0       = '0;
      acc_1       = '0;
      tick();
      tick();
      chk_idle("rst");
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_rd",  32'(host_rdata), 32'd0);
      reset = 1'b0;

      for (int a = 0; a < DEPTH; a++) host_wr(AW'(a), 8'($urandom));
      host_chk(5'd3, "rd3");

      // Same-cycle write and read of one address returns the old value.
      old_v      = mem_m[9];
      host_addr  = 5'd9;
      host_wdata = ~old_v;
      host_we    = 1'b1;
      tick();
      host_we    = 1'b0;
      chk("rd_prewr", 32'(host_rdata), 32'(old_v));
      mem_m[9]   = ~old_v;
      host_chk(5'd9, "rd_postwr");

      host_wr(5'd4, 8'h11);
      host_wr(5'd5, 8'h22);
      host_wr(5'd6, 8'h33);
      host_wr(5'd7, 8'h44);
      do_weight(5'd4, 2, 1'b0);
      chk("w_ovr0", 32'(overrun), 32'd0);
      do_input(5'd4, 1);
      chk("i_ovr0", 32'(overrun), 32'd0);

      // Store with wrap from 30 to 1.
      do_store(5'd30, 16'hBEEF, 16'h1234, -1, '0, '0, -1, 1'b0);
      host_chk_c(5'd30, 8'hEF, "st_30");
      host_chk_c(5'd31, 8'hBE, "st_31");
      host_chk_c(5'd0,  8'h34, "st_0");
      host_chk_c(5'd1,  8'h12, "st_1");

      // Host write to the address STORE writes in the same cycle.
      do_store(5'd0, 16'($urandom), 16'h1234, 2, 5'd2, 8'h55, -1, 1'b0);
      host_chk_c(5'd2, 8'h34, "coll_2");
      // Host write to an unrelated address during a STORE write cycle is dropped.
      old_v = mem_m[20];
      do_store(5'd12, 16'($urandom), 16'($urandom), 0, 5'd20, ~old_v, -1, 1'b0);
      host_chk(5'd20, "coll_other");
      for (int j = 0; j < 4; j++) host_chk(wa(5'd12, j), "coll_st");
      chk("coll_ovr0", 32'(overrun), 32'd0);

      // Randomized back-to-back operations.
      for (int it = 0; it < 12; it++) begin
         host_wr(5'($urandom), 8'($urandom));
         host_wr(5'($urandom), 8'($urandom));
         rb = 5'($urandom);
         op = $urandom_range(0, 2);
         if (op == 0) begin
            do_weight(rb, $urandom_range(1, 2), 1'b0);
         end else if (op == 1) begin
            do_input(rb, $urandom_range(1, IN_BEATS));
         end else begin
            do_store(rb, 16'($urandom), 16'($urandom), -1, '0, '0, -1, 1'b0);
            for (int j = 0; j < 4; j++) host_chk(wa(rb, j), "rnd_st");
         end
      end
      chk("rnd_ovr0", 32'(overrun), 32'd0);

      // Simultaneous edges: store wins, the others are dropped.
      do_store(5'd16, 16'($urandom), 16'($urandom), -1, '0, '0, -1, 1'b1);
      chk("sim_ovr", 32'(overrun), 32'd1);
      for (int j = 0; j < 4; j++) host_chk(wa(5'd16, j), "sim_st");

      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_ovr", 32'(overrun), 32'd0);

      // Input edge while a weight operation is running.
      do_weight(5'd4, 1, 1'b1);
      chk("ovr_set", 32'(overrun), 32'd1);
      do_input(5'd8, 1);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Reset after two STORE bytes: later bytes keep their old values.
      do_store(5'd10, 16'($urandom), 16'($urandom), -1, '0, '0, 2, 1'b0);
      for (int j = 0; j < 4; j++) host_chk(wa(5'd10, j), "rst_st");
      do_weight(5'd10, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
